// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair handshake between a PCM producer and the I2S transmitter.
//   SampleL/SampleR : stereo pair, two's complement, SAMPLE_W bits each
//   SampleValid     : producer offers a pair
//   SampleReady     : transmitter holding register is empty
// A pair transfers on any rising clock edge with SampleValid && SampleReady.
interface i2s_tx_serializer_if #(
  parameter int SAMPLE_W = 16
);
  logic [SAMPLE_W-1:0] SampleL;
  logic [SAMPLE_W-1:0] SampleR;
  logic                SampleValid;
  logic                SampleReady;

  modport master (output SampleL, SampleR, SampleValid, input  SampleReady);
  modport slave  (input  SampleL, SampleR, SampleValid, output SampleReady);
endinterface

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S transmitter running directly on I2SCLK.
// One stereo pair is buffered in a holding register ahead of the frame being
// shifted out; a frame boundary with an empty holding register sends a silent
// frame and is recorded as an underrun.
//
// Ports
//   I2SCLK        in   sole clock, rising edge
//   nReset        in   asynchronous active-low reset
//   Enable        in   run the serial interface
//   smp           if   sample handshake (slave side)
//   ClearStatus   in   clears Underrun / UnderrunCount
//   BCLK          out  bit clock, period 2*HALF_DIV I2SCLK cycles
//   LRCLK         out  word select (0 = left, 1 = right)
//   SDATA         out  serial data, MSB first, one BCLK after LRCLK changes
//   FrameStart    out  one-cycle pulse at each frame boundary
//   Underrun      out  sticky underrun flag
//   UnderrunCount out  saturating underrun count
module i2s_tx_serializer #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int HALF_DIV = 2
) (
  input  logic                I2SCLK,
  input  logic                nReset,
  input  logic                Enable,
  i2s_tx_serializer_if.slave  smp,
  input  logic                ClearStatus,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                SDATA,
  output logic                FrameStart,
  output logic                Underrun,
  output logic [7:0]          UnderrunCount
);

  localparam int BIT_W = $clog2(2*SLOT_W);
  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_W-1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);
  localparam logic [BIT_W-1:0] SMP_LEN  = BIT_W'(SAMPLE_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV-1);

  // run_q delays the divider start by one cycle after Enable rises so the
  // first frame boundary lands 2*HALF_DIV cycles after Enable is sampled.
  logic                run_q,       run_d;
  logic [DIV_W-1:0]    div_q,       div_d;
  logic                bclk_q,      bclk_d;
  logic [BIT_W-1:0]    bit_q,       bit_d;
  logic                lrclk_q,     lrclk_d;
  logic                sdata_q,     sdata_d;
  logic                fs_q,        fs_d;
  logic [SAMPLE_W-1:0] shl_q,       shl_d;
  logic [SAMPLE_W-1:0] shr_q,       shr_d;
  logic                hold_full_q, hold_full_d;
  logic [SAMPLE_W-1:0] hol_q,       hol_d;
  logic [SAMPLE_W-1:0] hor_q,       hor_d;
  logic                und_q,       und_d;
  logic [7:0]          ucnt_q,      ucnt_d;

  logic                accept;
  logic                fall;
  logic                boundary;
  logic [BIT_W-1:0]    bit_nxt;
  logic [BIT_W-1:0]    pos;
  logic [BIT_W-1:0]    shamt;
  logic [SAMPLE_W-1:0] word;
  logic [SAMPLE_W-1:0] shifted;

  always_comb begin
    run_d       = Enable;
    div_d       = div_q;
    bclk_d      = bclk_q;
    bit_d       = bit_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    fs_d        = 1'b0;
    shl_d       = shl_q;
    shr_d       = shr_q;
    hold_full_d = hold_full_q;
    hol_d       = hol_q;
    hor_d       = hor_q;
    und_d       = und_q;
    ucnt_d      = ucnt_q;
    fall        = 1'b0;
    boundary    = 1'b0;
    bit_nxt     = bit_q;
    pos         = '0;
    shamt       = '0;
    word        = '0;
    shifted     = '0;

    accept = smp.SampleValid && !hold_full_q;

    if (ClearStatus) begin
      und_d  = 1'b0;
      ucnt_d = 8'd0;
    end

    // Handshake runs regardless of Enable; accept implies the register was
    // empty, so it never collides with the boundary drain below.
    if (accept) begin
      hold_full_d = 1'b1;
      hol_d       = smp.SampleL;
      hor_d       = smp.SampleR;
    end

    if (!Enable) begin
      div_d   = '0;
      bclk_d  = 1'b0;
      bit_d   = BIT_LAST;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
      shl_d   = '0;
      shr_d   = '0;
    end else if (run_q) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        bclk_d = !bclk_q;
        fall   = bclk_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end

    if (fall) begin
      bit_nxt  = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
      bit_d    = bit_nxt;
      boundary = (bit_nxt == '0);
      lrclk_d  = (bit_nxt >= SLOT_LEN);
      pos      = lrclk_d ? bit_nxt - SLOT_LEN : bit_nxt;

      if (boundary) begin
        fs_d = 1'b1;
        if (hold_full_q) begin
          shl_d       = hol_q;
          shr_d       = hor_q;
          hold_full_d = 1'b0;
        end else begin
          shl_d  = '0;
          shr_d  = '0;
          und_d  = 1'b1;
          // A clear in the same cycle wipes the old count, then this
          // underrun is the first one counted.
          if (ClearStatus)         ucnt_d = 8'd1;
          else if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
        end
      end

      // Position 0 of each slot is the I2S one-bit delay; bits 1..SAMPLE_W
      // carry the sample MSB first. At the boundary pos is 0, so using the
      // pre-load shadow here is harmless.
      word    = lrclk_d ? shr_q : shl_q;
      shamt   = SMP_LEN - pos;
      shifted = word >> shamt;
      sdata_d = (pos != '0) && (pos <= SMP_LEN) && shifted[0];
    end
  end

  always_ff @(posedge I2SCLK or negedge nReset) begin
    if (!nReset) begin
      run_q       <= 1'b0;
      div_q       <= '0;
      bclk_q      <= 1'b0;
      bit_q       <= BIT_LAST;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      fs_q        <= 1'b0;
      shl_q       <= '0;
      shr_q       <= '0;
      hold_full_q <= 1'b0;
      hol_q       <= '0;
      hor_q       <= '0;
      und_q       <= 1'b0;
      ucnt_q      <= 8'd0;
    end else begin
      run_q       <= run_d;
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      bit_q       <= bit_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      fs_q        <= fs_d;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
      hold_full_q <= hold_full_d;
      hol_q       <= hol_d;
      hor_q       <= hor_d;
      und_q       <= und_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign smp.SampleReady = !hold_full_q;
  assign BCLK            = bclk_q;
  assign LRCLK           = lrclk_q;
  assign SDATA           = sdata_q;
  assign FrameStart      = fs_q;
  assign Underrun        = und_q;
  assign UnderrunCount   = ucnt_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
module tb_i2s_tx_serializer;
  localparam int SW    = 16;
  localparam int SL    = 32;
  localparam int HD    = 2;
  localparam int FRAME = 4*SL*HD;

  logic       I2SCLK = 1'b0;
  logic       nReset;
  logic       Enable;
  logic       ClearStatus;
  logic       BCLK, LRCLK, SDATA, FrameStart, Underrun;
  logic [7:0] UnderrunCount;

  i2s_tx_serializer_if #(.SAMPLE_W(SW)) smp();

  i2s_tx_serializer #(.SAMPLE_W(SW), .SLOT_W(SL), .HALF_DIV(HD)) dut (
    .I2SCLK        (I2SCLK),
    .nReset        (nReset),
    .Enable        (Enable),
    .smp           (smp),
    .ClearStatus   (ClearStatus),
    .BCLK          (BCLK),
    .LRCLK         (LRCLK),
    .SDATA         (SDATA),
    .FrameStart    (FrameStart),
    .Underrun      (Underrun),
    .UnderrunCount (UnderrunCount)
  );

  always #5 I2SCLK = ~I2SCLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge I2SCLK);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    smp.SampleL     = l;
    smp.SampleR     = r;
    smp.SampleValid = 1'b1;
    tick();
    smp.SampleValid = 1'b0;
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!FrameStart && n < FRAME + 50);
    if (!FrameStart) chk({tag, "_fs_timeout"}, 0, 1);
  endtask

  task automatic wait_falls(input int k);
    int   seen, t;
    logic prev;
    seen = 0; t = 0; prev = BCLK;
    while (seen < k && t < FRAME) begin
      tick();
      t++;
      if (prev && !BCLK) seen++;
      prev = BCLK;
    end
    if (seen < k) chk("falls_timeout", seen, k);
  endtask

  // Edges from the first edge that samples Enable high to the FrameStart edge.
  task automatic enable_latency(output int lat);
    int n;
    Enable = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!FrameStart && n < 20);
    lat = n - 1;
  endtask

  // Captures one frame starting at the current or next FrameStart: SDATA and
  // LRCLK at each BCLK falling event (bit 63 = position 0 of the left slot).
  task automatic cap_frame(output logic [31:0] l, output logic [31:0] r,
                           output logic [63:0] lr, output int t1, output int t33,
                           output logic [7:0] cnt, output logic ok);
    logic [63:0] sd;
    logic        prev, fs_seen;
    int          t, idx;
    sd = '0; lr = '0; t1 = -1; t33 = -1; t = 0; idx = 1;
    while (!FrameStart && t < FRAME + 50) begin
      tick();
      t++;
    end
    fs_seen = FrameStart;
    cnt     = UnderrunCount;
    sd[63]  = SDATA;
    lr[63]  = LRCLK;
    prev    = BCLK;
    t       = 0;
    while (idx < 64 && t < FRAME) begin
      tick();
      t++;
      if (prev && !BCLK) begin
        sd[63-idx] = SDATA;
        lr[63-idx] = LRCLK;
        if (idx == 1)  t1  = t;
        if (idx == 33) t33 = t;
        idx++;
      end
      prev = BCLK;
    end
    ok = fs_seen && (idx == 64);
    l  = sd[63:32];
    r  = sd[31:0];
  endtask

  function automatic logic [31:0] slot(input logic [15:0] s);
    return {1'b0, s, 15'b0};
  endfunction

  logic [15:0] pl [0:2];
  logic [15:0] pr [0:2];
  logic [31:0] cl, cr;
  logic [63:0] clr;
  int          ct1, ct33;
  logic [7:0]  ccnt;
  logic        cok;
  int          lat;

  localparam logic [63:0] LR_EXP = 64'h00000000_FFFFFFFF;

  initial begin
    pl[0] = 16'h1234; pr[0] = 16'hABCD;
    pl[1] = 16'h8000; pr[1] = 16'h0001;
    pl[2] = 16'hFFFF; pr[2] = 16'h5555;

    nReset = 1'b1; Enable = 1'b0; ClearStatus = 1'b0;
    smp.SampleL = '0; smp.SampleR = '0; smp.SampleValid = 1'b0;
    #2 nReset = 1'b0;

    // reset state
    repeat (3) tick();
    chk("rst_bclk", BCLK, 0);
    chk("rst_lrclk", LRCLK, 0);
    chk("rst_sdata", SDATA, 0);
    chk("rst_fs", FrameStart, 0);
    chk("rst_und", Underrun, 0);
    chk("rst_cnt", UnderrunCount, 0);
    nReset = 1'b1;
    tick();
    chk("rst_ready", smp.SampleReady, 1);

    // single frame A5F0 / 0F0F
    push(16'hA5F0, 16'h0F0F);
    chk("load_busy", smp.SampleReady, 0);
    enable_latency(lat);
    chk("fs_latency", lat, 4);
    chk("fs_ready", smp.SampleReady, 1);
    cap_frame(cl, cr, clr, ct1, ct33, ccnt, cok);
    chk("f1_ok", cok, 1);
    chk("f1_left", cl, 32'h52F80000);
    chk("f1_right", cr, 32'h07878000);
    chk("f1_lrclk", clr, LR_EXP);
    chk("f1_left_msb_t", ct1, 4);
    chk("f1_right_msb_t", ct33, 132);
    chk("f1_cnt", ccnt, 0);

    // underrun: silent frame, then saturation
    cap_frame(cl, cr, clr, ct1, ct33, ccnt, cok);
    chk("f2_ok", cok, 1);
    chk("f2_left", cl, 0);
    chk("f2_right", cr, 0);
    chk("f2_cnt", ccnt, 1);
    chk("f2_und", Underrun, 1);
    for (int k = 1; k <= 256; k++) begin
      wait_fs("starve");
      if (k == 253) chk("cnt_254", UnderrunCount, 254);
      if (k == 254) chk("cnt_255", UnderrunCount, 255);
    end
    chk("cnt_sat", UnderrunCount, 255);

    // clear away from a boundary
    repeat (10) tick();
    ClearStatus = 1'b1;
    tick();
    ClearStatus = 1'b0;
    chk("clr_und", Underrun, 0);
    chk("clr_cnt", UnderrunCount, 0);

    // clear colliding with an underrun boundary at count 5
    repeat (5) wait_fs("und5");
    chk("und5_cnt", UnderrunCount, 5);
    repeat (FRAME - 1) tick();
    ClearStatus = 1'b1;
    tick();
    ClearStatus = 1'b0;
    chk("coll_fs", FrameStart, 1);
    chk("coll_und", Underrun, 1);
    chk("coll_cnt", UnderrunCount, 1);

    // backpressure: P1..P3 with SampleValid held high
    fork
      begin
        int   i, t;
        logic rdy;
        i = 0; t = 0;
        smp.SampleL = pl[0]; smp.SampleR = pr[0]; smp.SampleValid = 1'b1;
        while (i < 3 && t < 4*FRAME) begin
          rdy = smp.SampleReady;
          if (rdy && i > 0) chk($sformatf("p%0d_at_fs", i+1), FrameStart, 1);
          tick();
          t++;
          if (rdy) begin
            i++;
            if (i == 1) chk("p1_then_busy", smp.SampleReady, 0);
            if (i < 3) begin
              smp.SampleL = pl[i];
              smp.SampleR = pr[i];
            end
          end
        end
        smp.SampleValid = 1'b0;
        chk("bp_accepted", i, 3);
      end
      begin
        tick();
        for (int f = 0; f < 3; f++) begin
          cap_frame(cl, cr, clr, ct1, ct33, ccnt, cok);
          chk($sformatf("bp%0d_ok", f+1), cok, 1);
          chk($sformatf("bp%0d_left", f+1), cl, slot(pl[f]));
          chk($sformatf("bp%0d_right", f+1), cr, slot(pr[f]));
          chk($sformatf("bp%0d_cnt", f+1), ccnt, 1);
        end
      end
    join

    // enable drop in the middle of a left slot
    push(16'hFFFF, 16'hFFFF);
    chk("p4_busy", smp.SampleReady, 0);
    wait_fs("p4");
    chk("p4_cnt", UnderrunCount, 1);
    wait_falls(8);
    tick(); tick();
    chk("drop_pre_bclk", BCLK, 1);
    chk("drop_pre_sdata", SDATA, 1);
    Enable = 1'b0;
    tick();
    chk("drop_bclk", BCLK, 0);
    chk("drop_lrclk", LRCLK, 0);
    chk("drop_sdata", SDATA, 0);
    chk("drop_ready", smp.SampleReady, 1);
    push(16'h8001, 16'h7FFE);
    chk("p5_held", smp.SampleReady, 0);
    repeat (20) tick();
    chk("drop_idle_bclk", BCLK, 0);
    chk("drop_cnt", UnderrunCount, 1);
    enable_latency(lat);
    chk("reen_latency", lat, 4);
    cap_frame(cl, cr, clr, ct1, ct33, ccnt, cok);
    chk("p5_ok", cok, 1);
    chk("p5_left", cl, 32'h40008000);
    chk("p5_right", cr, 32'h3FFF0000);
    chk("p5_cnt", ccnt, 1);

    // asynchronous reset in the middle of a right slot
    tick(); tick();
    chk("arst_pre_bclk", BCLK, 1);
    chk("arst_pre_lrclk", LRCLK, 1);
    #3 nReset = 1'b0;
    #1;
    chk("arst_bclk", BCLK, 0);
    chk("arst_lrclk", LRCLK, 0);
    chk("arst_sdata", SDATA, 0);
    chk("arst_fs", FrameStart, 0);
    chk("arst_und", Underrun, 0);
    chk("arst_cnt", UnderrunCount, 0);
    Enable = 1'b0;
    tick(); tick();
    nReset = 1'b1;
    tick();
    chk("arst_ready", smp.SampleReady, 1);
    chk("arst_idle_bclk", BCLK, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
